// File: rtl/serial_addr_decoder.sv
// serial_addr_decoder: deserialises an LSB-first address and holds the matching target until released
//
// Optional feature macro: SERIAL_ADDR_DEC_TIMEOUT_EN (forced release after TIMEOUT_CYC hold cycles)
//
// Ports:
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   bus_data_in       in   serial address bit
//   bus_data_in_valid in   bus_data_in carries a valid bit this cycle
//   bus_mode          in   1 = data phase, 0 = address phase
//   release_valids    in   per-target single-cycle release strobes
//   target_valid      out  one-hot held target
//   sel               out  index of held target, 0 when none
//   busy              out  high while a decode is pending or a target is held
//   decode_err        out  one-cycle pulse on an unmapped address
//   timeout           out  one-cycle pulse on a forced release (0 without the macro)
module serial_addr_decoder #(
    parameter int ADDR_W = 16,
    parameter int N_TGT = 3,
    parameter int SEL_W = $clog2(N_TGT),
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = {16'h8000, 16'h4000, 16'h0000},
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK = {16'hF000, 16'hC000, 16'hF800},
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_data_in,
    input  logic             bus_data_in_valid,
    input  logic             bus_mode,
    input  logic [N_TGT-1:0] release_valids,
    output logic [N_TGT-1:0] target_valid,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             decode_err,
    output logic             timeout
);
    localparam int CNT_W = $clog2(ADDR_W);
    typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    // Only ADDR_W-1 bits are stored: the final bit is taken straight from the bus.
    logic [ADDR_W-2:0] shreg, shreg_n;
    logic [ADDR_W-1:0] addr;
    logic [N_TGT-1:0] pend, pend_n, match, load, held, tv_n;
    logic [SEL_W-1:0] sel_n;
    logic err_n, to_n;
`ifdef SERIAL_ADDR_DEC_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr, tmr_n;
`endif

    function automatic logic [SEL_W-1:0] enc(input logic [N_TGT-1:0] v);
        logic [SEL_W-1:0] s;
        s = '0;
        for (int i = 0; i < N_TGT; i++)
            if (v[i]) s = s | SEL_W'(i);
        return s;
    endfunction

    always_comb begin
        addr = {bus_data_in, shreg};
        match = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (((addr ^ TGT_BASE[i*ADDR_W +: ADDR_W]) & TGT_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
                match = '0;
                match[i] = 1'b1;
            end
        end
        load = pend & ~release_valids;
        held = target_valid & ~release_valids;
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        shreg_n = shreg;
        pend_n = pend;
        tv_n = target_valid;
        sel_n = sel;
        err_n = 1'b0;
        to_n = 1'b0;
`ifdef SERIAL_ADDR_DEC_TIMEOUT_EN
        tmr_n = tmr;
`endif
        case (state)
            IDLE: begin
                if (!bus_mode) begin
                    if (bus_data_in_valid) begin
                        shreg_n = addr[ADDR_W-1:1];
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            pend_n = match;
                            cnt_n = '0;
                            state_n = PEND;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else begin
                        shreg_n = '0;
                        cnt_n = '0;
                    end
                end
            end
            PEND: begin
                tv_n = load;
                sel_n = enc(load);
                err_n = ~|pend;
                state_n = |load ? HOLD : IDLE;
`ifdef SERIAL_ADDR_DEC_TIMEOUT_EN
                tmr_n = '0;
`endif
            end
            HOLD: begin
                tv_n = held;
                if (~|held) begin
                    sel_n = '0;
                    state_n = IDLE;
                end
`ifdef SERIAL_ADDR_DEC_TIMEOUT_EN
                // A release emptying the hold on the expiry edge wins over the timeout.
                else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
                    tv_n = '0;
                    sel_n = '0;
                    to_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            shreg <= '0;
            pend <= '0;
            target_valid <= '0;
            sel <= '0;
            busy <= 1'b0;
            decode_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            shreg <= shreg_n;
            pend <= pend_n;
            target_valid <= tv_n;
            sel <= sel_n;
            busy <= state_n != IDLE;
            decode_err <= err_n;
            timeout <= to_n;
        end
    end

`ifdef SERIAL_ADDR_DEC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmr <= '0;
        else tmr <= tmr_n;
    end
`endif
endmodule

// File: tb/tb_serial_addr_decoder.sv
// tb_serial_addr_decoder: directed vector bench for serial_addr_decoder
module tb_serial_addr_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic dv = 1'b0;
    logic mode = 1'b1;
    logic [2:0] rel = 3'b000;
    logic [2:0] tv;
    logic [1:0] sel;
    logic busy, err, to;
    int checks = 0;
    int failures = 0;

    serial_addr_decoder #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus_data_in(din), .bus_data_in_valid(dv),
        .bus_mode(mode), .release_valids(rel), .target_valid(tv), .sel(sel),
        .busy(busy), .decode_err(err), .timeout(to)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  rel;
        logic [2:0]  tv;
        logic [1:0]  sel;
        logic        err;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        mode = 1'b0;
        dv = 1'b1;
        din = b;
        tick();
        mode = 1'b1;
        dv = 1'b0;
    endtask

    task automatic send_n(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) send_bit(a[i]);
    endtask

    task automatic release_all(input logic [2:0] r);
        rel = r;
        tick();
        rel = 3'b000;
        chk("rel_tv", tv, 0);
        chk("rel_busy", busy, 0);
        chk("rel_sel", sel, 0);
    endtask

    initial begin
        vecs[0]  = '{16'h0123, 3'b000, 3'b001, 2'd0, 1'b0};
        vecs[1]  = '{16'h4ABC, 3'b000, 3'b010, 2'd1, 1'b0};
        vecs[2]  = '{16'h8001, 3'b000, 3'b100, 2'd2, 1'b0};
        vecs[3]  = '{16'hC000, 3'b000, 3'b000, 2'd0, 1'b1};
        vecs[4]  = '{16'h0123, 3'b001, 3'b000, 2'd0, 1'b0};
        vecs[5]  = '{16'h0123, 3'b110, 3'b001, 2'd0, 1'b0};
        vecs[6]  = '{16'h07FF, 3'b000, 3'b001, 2'd0, 1'b0};
        vecs[7]  = '{16'h0800, 3'b000, 3'b000, 2'd0, 1'b1};
        vecs[8]  = '{16'h7FFF, 3'b000, 3'b010, 2'd1, 1'b0};
        vecs[9]  = '{16'h8FFF, 3'b000, 3'b100, 2'd2, 1'b0};
        vecs[10] = '{16'h9000, 3'b000, 3'b000, 2'd0, 1'b1};

        #12;
        chk("rst_tv", tv, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_to", to, 0);
        chk("rst_cnt", dut.cnt, 0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 11; k++) begin
            send_n(vecs[k].addr, 16);
            chk("vec_busy_E", busy, 1);
            chk("vec_tv_E", tv, 0);
            rel = vecs[k].rel;
            tick();
            rel = 3'b000;
            chk("vec_tv", tv, vecs[k].tv);
            chk("vec_sel", sel, vecs[k].sel);
            chk("vec_err", err, vecs[k].err);
            chk("vec_busy", busy, |vecs[k].tv);
            if (|vecs[k].tv) release_all(vecs[k].tv);
            tick();
            chk("vec_err_once", err, 0);
        end

        // Bits during HOLD are dropped; non-held releases do nothing.
        send_n(16'h4ABC, 16);
        tick();
        send_n(16'hFFFF, 5);
        chk("hold_cnt", dut.cnt, 0);
        chk("hold_tv", tv, 3'b010);
        chk("hold_busy", busy, 1);
        rel = 3'b101;
        tick();
        rel = 3'b000;
        chk("hold_other_rel", tv, 3'b010);
        release_all(3'b010);
        // New address accepted starting on the edge after busy fell.
        send_n(16'h8001, 16);
        tick();
        chk("back2back_tv", tv, 3'b100);
        chk("back2back_sel", sel, 2);
        release_all(3'b100);

        // Gap abort clears the partial address.
        send_n(16'hFFFF, 7);
        chk("gap_cnt_pre", dut.cnt, 7);
        mode = 1'b0;
        tick();
        mode = 1'b1;
        chk("gap_cnt", dut.cnt, 0);
        send_n(16'h0123, 16);
        tick();
        chk("gap_tv", tv, 3'b001);
        release_all(3'b001);

        // Data phase freezes a partial address.
        send_n(16'h0123, 8);
        mode = 1'b1;
        dv = 1'b1;
        din = 1'b1;
        repeat (3) tick();
        dv = 1'b0;
        chk("mode_cnt", dut.cnt, 8);
        send_n(16'h0001, 8);
        tick();
        chk("mode_tv", tv, 3'b001);
        release_all(3'b001);

        // Reset mid-shift and mid-hold.
        send_n(16'h00FF, 5);
        rst_n = 1'b0;
        #1;
        chk("rstmid_cnt", dut.cnt, 0);
        chk("rstmid_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        send_n(16'h4ABC, 16);
        tick();
        chk("rsthold_pre", tv, 3'b010);
        rst_n = 1'b0;
        #1;
        chk("rsthold_tv", tv, 0);
        chk("rsthold_sel", sel, 0);
        chk("rsthold_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        send_n(16'h0123, 16);
        tick();
        chk("rst_after_tv", tv, 3'b001);
        release_all(3'b001);

`ifdef SERIAL_ADDR_DEC_TIMEOUT_EN
        send_n(16'h4ABC, 16);
        tick();
        repeat (7) tick();
        chk("to_pre_tv", tv, 3'b010);
        chk("to_pre", to, 0);
        tick();
        chk("to_pulse", to, 1);
        chk("to_tv", tv, 0);
        chk("to_busy", busy, 0);
        tick();
        chk("to_once", to, 0);
        send_n(16'h4ABC, 16);
        tick();
        repeat (7) tick();
        rel = 3'b010;
        tick();
        rel = 3'b000;
        chk("to_rel_wins", to, 0);
        chk("to_rel_tv", tv, 0);
        chk("to_rel_busy", busy, 0);
`else
        send_n(16'h4ABC, 16);
        tick();
        repeat (20) tick();
        chk("noto_tv", tv, 3'b010);
        chk("noto_to", to, 0);
        release_all(3'b010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
